rr_req_agent: RTL and testbench
===============================

Name: rr_req_agent

Overview:
- Requester-side front end for the 4-way round-robin arbiter. It is the initiator end of the req/grant interface.
- Four clients post job pulses. Each channel queues a pending-job count and drives its request line to the arbiter. For each job it performs a BURST_LEN-beat transfer while granted, then releases.
- It drives the arbiter's `in[3:0]` and consumes the arbiter's one-hot `out[3:0]` as `gnt`. It reports beats and completions to the shared-resource side.

Parameters:
- CNT_W, 3: width of the per-channel pending-job counter. Maximum pending is 2^CNT_W-1 = 7.
- BURST_LEN, 4: beats per job, legal range 1..16. The beat counter is 4 bits.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- job_in  in  4  one-cycle pulse per channel; each pulse queues one job.
- gnt  in  4  one-hot grant from the arbiter; 0000 means idle.
- req  out  4  request lines to the arbiter.
- xfer_valid  out  1  a granted beat is transferred this cycle.
- xfer_ch  out  2  channel index of the current beat; 0 when xfer_valid=0.
- done  out  4  one-cycle pulse when channel i completes its final beat.
- ovf  out  4  sticky; job_in[i] arrived while pend[i] was at maximum.
- gnt_err  out  1  sticky; illegal grant was detected.

Behaviour:
- Reset (async, rst_n=0):
  - all channels go to IDLE; pend, beat counters and all outputs are 0.
  - Reset mid-burst discards the burst and all pending jobs. No done pulse is generated.
- Per-channel FSM, registered state:
  - IDLE: if pend>0, go to REQ next cycle.
  - REQ: req[i]=1. If gnt[i]=1, the beat occurs this cycle and the channel goes to XFER (or REL if BURST_LEN=1).
  - XFER: req[i]=1. Each cycle with gnt[i]=1 is a beat and increments beat[i].
    - gnt[i]=0 (the arbiter rotated to another channel): stay in XFER, hold beat[i], keep req[i]=1. The burst resumes on the next grant.
  - Final beat (beat[i]==BURST_LEN-1 with gnt[i]=1): pulse done[i] in that cycle, decrement pend[i], clear beat[i], go to REL.
  - REL: req[i]=0 for exactly one cycle, so the arbiter sees the release. Next state is REQ if pend>0, else IDLE.
- req is registered (a function of state only), with no combinational path from gnt to req.
- Grant latency: the arbiter responds one cycle after req rises. The agent never depends on a specific latency and waits indefinitely in REQ.
- Beat outputs: xfer_valid = OR over i of (gnt[i] & state_i in {REQ, XFER}); xfer_ch = encoded index of that gnt bit. Both are combinational from gnt and state.
- Pending counter:
  - job_in[i] alone: +1, saturating at 7.
  - job_in[i] at maximum: count unchanged, ovf[i] set.
  - job_in[i] in the same cycle as the final beat: count unchanged (+1 -1), no ovf.
- gnt_err is set on any of:
  - more than one gnt bit high;
  - gnt[i]=1 while channel i is IDLE or REL.
  An erroneous grant never counts as a beat. A multi-hot grant produces no beat on any channel.
- Channels are independent. Only one beat is possible per cycle, enforced by the one-hot grant.

Decomposition:
- Shared package rr_pkg:
  - N_CH=4;
  - channel state encoding IDLE=2'b00, REQ=2'b01, XFER=2'b10, REL=2'b11;
  - BURST_LEN default.
- One sub-module rr_req_chan, instantiated four times. It holds the FSM, pend counter, beat counter, and req/done/ovf for a single channel.
- The top level holds the gnt legality check, xfer_valid/xfer_ch encoding and gnt_err.

Test Plan:
1. Reset, then one job_in[2] pulse; bench arbiter returns gnt=0100 one cycle after req → req=0100 held. xfer_valid=1 with xfer_ch=2 for 4 consecutive cycles, done[2] on the 4th beat. req low for exactly one cycle (REL), then req=0000.
2. job_in[0] and job_in[1] in the same cycle, with grants alternating 0001/0010 each cycle → each channel gets 4 beats interleaved, beat counts are held across gaps, and done[0]/done[1] each pulse exactly once after 8 total beats.
3. 8 job_in[3] pulses with no grant → pend=7, ovf[3]=1 after the 8th pulse. req[3] stays high; with continuous grant, done[3] pulses 7 times.
4. job_in[1] coincident with the final beat of channel 1's single pending job → pend stays 1, REL lasts 1 cycle, then REQ and a second burst of 4 beats.
5. gnt=0011 while channels 0 and 1 are both in REQ → gnt_err=1 and sticky, no beat counted, xfer_valid semantics unaffected on subsequent legal grants. gnt=1000 while channel 3 is IDLE → gnt_err set.
6. rst_n dropped asynchronously mid-burst (beat 2 of 4, pend=3) → req, done, xfer_valid, pend go to 0 immediately. After release, no activity until a new job_in.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin requester agent.
package rr_pkg;

   localparam int N_CH          = 4;
   localparam int CNT_W_DEF     = 3;
   localparam int BURST_LEN_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_XFER = 2'b10,
      ST_REL  = 2'b11
   } ch_state_t;

endpackage

// File: rtl/rr_req_chan.sv
// One requester channel: job queue, request FSM and beat counter.
//
//  state | meaning
//  IDLE  | no pending job, request low
//  REQ   | request raised, waiting for the first grant of a burst
//  XFER  | burst in progress; beats advance only on grant, held across gaps
//  REL   | request dropped for one cycle so the arbiter sees the release
module rr_req_chan
   import rr_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_job,
   input  logic i_gnt,
   input  logic i_gnt_multi,
   output logic o_req,
   output logic o_active,
   output logic o_beat,
   output logic o_done,
   output logic o_ovf
);

   localparam logic [CNT_W-1:0] PEND_MAX  = '1;
   localparam logic [3:0]       LAST_BEAT = 4'(BURST_LEN - 1);

   ch_state_t        r_state;
   ch_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_pend;
   logic [3:0]       r_beat;
   logic             r_ovf;
   logic             w_active;
   logic             w_beat;
   logic             w_final;

   // A multi-hot grant is never a beat, even for a channel that is requesting.
   assign w_active = (r_state == ST_REQ) || (r_state == ST_XFER);
   assign w_beat   = i_gnt & ~i_gnt_multi & w_active;
   assign w_final  = w_beat & (r_beat == LAST_BEAT);

   assign o_req    = w_active;
   assign o_active = w_active;
   assign o_beat   = w_beat;
   assign o_done   = w_final;
   assign o_ovf    = r_ovf;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; REL looks at the already-decremented pending count.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (r_pend != '0) w_state_nxt = ST_REQ;
         ST_REQ:  if (w_beat)       w_state_nxt = w_final ? ST_REL : ST_XFER;
         ST_XFER: if (w_final)      w_state_nxt = ST_REL;
         ST_REL:  w_state_nxt = (r_pend != '0) ? ST_REQ : ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Pending-job counter with saturation and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_ovf  <= 1'b0;
      end else if (i_job && !w_final) begin
         if (r_pend == PEND_MAX) r_ovf  <= 1'b1;
         else                    r_pend <= r_pend + 1'b1;
      end else if (!i_job && w_final) begin
         r_pend <= r_pend - 1'b1;
      end
   end

   // Beat counter, held while the grant is elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_beat <= '0;
      else if (w_final) r_beat <= '0;
      else if (w_beat)  r_beat <= r_beat + 4'd1;
   end

endmodule

// File: rtl/rr_req_agent.sv
// Four-channel requester front end for the round-robin arbiter.
module rr_req_agent
   import rr_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] job_in,
   input  logic [N_CH-1:0] gnt,
   output logic [N_CH-1:0] req,
   output logic            xfer_valid,
   output logic [1:0]      xfer_ch,
   output logic [N_CH-1:0] done,
   output logic [N_CH-1:0] ovf,
   output logic            gnt_err
);

   logic [N_CH-1:0] w_active;
   logic [N_CH-1:0] w_beat;
   logic            w_gnt_multi;
   logic            w_gnt_bad;
   logic            r_gnt_err;

   assign w_gnt_multi = |(gnt & (gnt - 4'd1));
   assign w_gnt_bad   = w_gnt_multi | (|(gnt & ~w_active));
   assign gnt_err     = r_gnt_err;

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      rr_req_chan #(
         .CNT_W     (CNT_W),
         .BURST_LEN (BURST_LEN)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_job       (job_in[g]),
         .i_gnt       (gnt[g]),
         .i_gnt_multi (w_gnt_multi),
         .o_req       (req[g]),
         .o_active    (w_active[g]),
         .o_beat      (w_beat[g]),
         .o_done      (done[g]),
         .o_ovf       (ovf[g])
      );
   end

   // Sticky record of any illegal grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_gnt_err <= 1'b0;
      else if (w_gnt_bad) r_gnt_err <= 1'b1;
   end

   // Encode the (at most one) beating channel.
   always_comb begin
      xfer_valid = |w_beat;
      xfer_ch    = 2'd0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_beat[i]) xfer_ch = 2'(i);
      end
   end

endmodule

// File: tb/tb_rr_req_agent.sv
// Directed bench for rr_req_agent: a vector table plus hand-written corner sequences.
module tb_rr_req_agent;

   logic       clk;
   logic       rst_n;
   logic [3:0] job_in;
   logic [3:0] gnt;
   logic [3:0] req;
   logic       xfer_valid;
   logic [1:0] xfer_ch;
   logic [3:0] done;
   logic [3:0] ovf;
   logic       gnt_err;

   int n_checks = 0;
   int n_errors = 0;

   rr_req_agent dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .job_in     (job_in),
      .gnt        (gnt),
      .req        (req),
      .xfer_valid (xfer_valid),
      .xfer_ch    (xfer_ch),
      .done       (done),
      .ovf        (ovf),
      .gnt_err    (gnt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] job;
      logic [3:0] gnt;
      logic [3:0] req;
      logic       xv;
      logic [1:0] ch;
      logic [3:0] done;
      logic       err;
   } vec_t;

   vec_t vq[$];

   task automatic v(input logic rst, input logic [3:0] j, input logic [3:0] g,
                    input logic [3:0] rq, input logic xv, input logic [1:0] ch,
                    input logic [3:0] dn, input logic err);
      vec_t e;
      e.rst = rst; e.job = j; e.gnt = g; e.req = rq;
      e.xv = xv; e.ch = ch; e.done = dn; e.err = err;
      vq.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; leaves at posedge+1 with rst_n released.
   task automatic do_reset();
      job_in = 4'd0;
      gnt    = 4'd0;
      rst_n  = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [3:0] j, input logic [3:0] g);
      job_in = j;
      gnt    = g;
      @(posedge clk); #1;
   endtask

   int n_done;
   int n_beat;

   initial begin
      rst_n  = 1'b0;
      job_in = 4'd0;
      gnt    = 4'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #4;
      chk("reset_req",  {4'd0, req},  8'h00);
      chk("reset_done", {4'd0, done}, 8'h00);
      chk("reset_ovf",  {4'd0, ovf},  8'h00);
      chk("reset_err",  {7'd0, gnt_err}, 8'h00);
      @(posedge clk); #1;

      // single job on channel 2, grant one cycle after req
      v(1,4'b0100,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0100,0,0,4'b0000,0);
      v(0,4'b0000,4'b0100,4'b0100,1,2,4'b0000,0);
      v(0,4'b0000,4'b0100,4'b0100,1,2,4'b0000,0);
      v(0,4'b0000,4'b0100,4'b0100,1,2,4'b0000,0);
      v(0,4'b0000,4'b0100,4'b0100,1,2,4'b0100,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      // channels 0 and 1 interleaved
      v(1,4'b0011,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0011,0,0,4'b0000,0);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0011,1,1,4'b0000,0);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0011,1,1,4'b0000,0);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0011,1,1,4'b0000,0);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0001,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0010,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      // job on channel 1 coincident with its final beat
      v(1,4'b0010,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,0);
      v(0,4'b0010,4'b0010,4'b0010,1,1,4'b0010,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0010,0,0,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,0);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0010,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      // multi-hot grant: error, no beat counted
      v(1,4'b0011,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0011,4'b0011,0,0,4'b0000,0);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0000,1);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0000,1);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0000,1);
      v(0,4'b0000,4'b0001,4'b0011,1,0,4'b0001,1);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,1);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,1);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0000,1);
      v(0,4'b0000,4'b0010,4'b0010,1,1,4'b0010,1);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,1);
      // grant to idle channel 3
      v(1,4'b0000,4'b1000,4'b0000,0,0,4'b0000,0);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,1);
      v(0,4'b0000,4'b0000,4'b0000,0,0,4'b0000,1);

      foreach (vq[k]) begin
         if (vq[k].rst) do_reset();
         job_in = vq[k].job;
         gnt    = vq[k].gnt;
         #4;
         chk($sformatf("row%0d_req", k),  {4'd0, req},        {4'd0, vq[k].req});
         chk($sformatf("row%0d_xv", k),   {7'd0, xfer_valid}, {7'd0, vq[k].xv});
         if (vq[k].xv)
            chk($sformatf("row%0d_ch", k), {6'd0, xfer_ch},   {6'd0, vq[k].ch});
         chk($sformatf("row%0d_done", k), {4'd0, done},       {4'd0, vq[k].done});
         chk($sformatf("row%0d_ovf", k),  {4'd0, ovf},        8'h00);
         chk($sformatf("row%0d_err", k),  {7'd0, gnt_err},    {7'd0, vq[k].err});
         @(posedge clk); #1;
      end

      // overflow on channel 3 then drain with continuous grant
      do_reset();
      for (int k = 0; k < 7; k++) run(4'b1000, 4'b0000);
      chk("ovf_before_8th", {4'd0, ovf}, 8'h00);
      run(4'b1000, 4'b0000);
      chk("ovf_after_8th", {4'd0, ovf}, 8'h08);
      chk("req3_waiting",  {4'd0, req}, 8'h08);
      n_done = 0;
      n_beat = 0;
      for (int k = 0; k < 40; k++) begin
         job_in = 4'd0;
         gnt    = req;
         #4;
         if (done[3])    n_done++;
         if (xfer_valid) n_beat++;
         @(posedge clk); #1;
      end
      chk("drain_done_cnt", 8'(n_done), 8'd7);
      chk("drain_beat_cnt", 8'(n_beat), 8'd28);
      chk("drain_req_idle", {4'd0, req}, 8'h00);
      chk("drain_ovf_sticky", {4'd0, ovf}, 8'h08);
      chk("drain_no_err", {7'd0, gnt_err}, 8'h00);

      // asynchronous reset mid-burst
      do_reset();
      run(4'b0001, 4'b0000);
      run(4'b0001, 4'b0000);
      run(4'b0001, 4'b0000);
      run(4'b0000, 4'b0001);
      run(4'b0000, 4'b0001);
      job_in = 4'd0;
      gnt    = 4'b0001;
      #4;
      chk("pre_rst_xv", {7'd0, xfer_valid}, 8'h01);
      chk("pre_rst_req", {4'd0, req}, 8'h01);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_req",  {4'd0, req},        8'h00);
      chk("async_rst_xv",   {7'd0, xfer_valid}, 8'h00);
      chk("async_rst_done", {4'd0, done},       8'h00);
      gnt = 4'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         job_in = 4'd0;
         gnt    = 4'd0;
         #4;
         chk($sformatf("post_rst%0d_req", k), {4'd0, req}, 8'h00);
         @(posedge clk); #1;
      end
      chk("post_rst_err", {7'd0, gnt_err}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
